// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match controller: collects two one-hot throws,
// judges the round, keeps score. Optional forfeit timeout enabled by RPS_TIMEOUT_EN.
module rps_match_ctrl #(
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 10,
    parameter int TIMEOUT   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_match,
    input  logic [2:0]         choice1,
    input  logic               commit1,
    input  logic [2:0]         choice2,
    input  logic               commit2,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               locked1,
    output logic               locked2,
    output logic               match_over,
    output logic [1:0]         winner,
    output logic               forfeit
);

    if (WIN_SCORE < 1 || WIN_SCORE > (1 << SCORE_W) - 1 || TIMEOUT < 1) begin : g_bad_params
        $error("rps_match_ctrl: WIN_SCORE must fit in SCORE_W bits and TIMEOUT must be positive");
    end

    typedef enum logic [1:0] {COLLECT, JUDGE, OVER} state_t;

    state_t             state, state_n;
    logic [2:0]         throw1, throw1_n, throw2, throw2_n;
    logic               locked1_n, locked2_n, result_valid_n, match_over_n;
    logic [1:0]         result_n, winner_n, round_win;
    logic [SCORE_W-1:0] score1_n, score2_n;

    function automatic logic one_hot(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

`ifdef RPS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             fft, fft_n, forfeit_n;
`endif

    // Bit 0 = rock, bit 1 = paper, bit 2 = scissors; a forfeit round goes to the locked player.
    always_comb begin
        round_win[0] = (throw1[0] & throw2[2]) | (throw1[1] & throw2[0]) | (throw1[2] & throw2[1]);
        round_win[1] = (throw2[0] & throw1[2]) | (throw2[1] & throw1[0]) | (throw2[2] & throw1[1]);
`ifdef RPS_TIMEOUT_EN
        if (fft) begin
            round_win = locked1 ? 2'b01 : 2'b10;
        end
`endif
    end

    always_comb begin
        state_n        = state;
        throw1_n       = throw1;
        throw2_n       = throw2;
        locked1_n      = locked1;
        locked2_n      = locked2;
        result_n       = result;
        result_valid_n = 1'b0;
        score1_n       = score1;
        score2_n       = score2;
        match_over_n   = match_over;
        winner_n       = winner;
`ifdef RPS_TIMEOUT_EN
        cnt_n          = cnt;
        fft_n          = fft;
        forfeit_n      = 1'b0;
`endif
        if (new_match) begin
            state_n      = COLLECT;
            throw1_n     = '0;
            throw2_n     = '0;
            locked1_n    = 1'b0;
            locked2_n    = 1'b0;
            result_n     = '0;
            score1_n     = '0;
            score2_n     = '0;
            match_over_n = 1'b0;
            winner_n     = '0;
`ifdef RPS_TIMEOUT_EN
            cnt_n        = '0;
            fft_n        = 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (commit1 && !locked1 && one_hot(choice1)) begin
                        throw1_n  = choice1;
                        locked1_n = 1'b1;
                    end
                    if (commit2 && !locked2 && one_hot(choice2)) begin
                        throw2_n  = choice2;
                        locked2_n = 1'b1;
                    end
                    if (locked1_n && locked2_n) begin
                        state_n = JUDGE;
`ifdef RPS_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end
`ifdef RPS_TIMEOUT_EN
                    // Counting starts on the edge that locks the first player.
                    else if (locked1_n ^ locked2_n) begin
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt_n == CNT_W'(TIMEOUT)) begin
                            state_n = JUDGE;
                            fft_n   = 1'b1;
                            cnt_n   = '0;
                        end
                    end else begin
                        cnt_n = '0;
                    end
`endif
                end
                JUDGE: begin
                    result_n       = round_win;
                    result_valid_n = 1'b1;
                    locked1_n      = 1'b0;
                    locked2_n      = 1'b0;
                    throw1_n       = '0;
                    throw2_n       = '0;
                    state_n        = COLLECT;
                    if (round_win == 2'b01) begin
                        score1_n = score1 + SCORE_W'(1);
                        if (score1_n == SCORE_W'(WIN_SCORE)) begin
                            state_n      = OVER;
                            match_over_n = 1'b1;
                            winner_n     = 2'b01;
                        end
                    end else if (round_win == 2'b10) begin
                        score2_n = score2 + SCORE_W'(1);
                        if (score2_n == SCORE_W'(WIN_SCORE)) begin
                            state_n      = OVER;
                            match_over_n = 1'b1;
                            winner_n     = 2'b10;
                        end
                    end
`ifdef RPS_TIMEOUT_EN
                    forfeit_n = fft;
                    fft_n     = 1'b0;
                    cnt_n     = '0;
`endif
                end
                OVER: begin
                end
                default: state_n = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            throw1       <= '0;
            throw2       <= '0;
            locked1      <= 1'b0;
            locked2      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            score1       <= '0;
            score2       <= '0;
            match_over   <= 1'b0;
            winner       <= '0;
        end else begin
            state        <= state_n;
            throw1       <= throw1_n;
            throw2       <= throw2_n;
            locked1      <= locked1_n;
            locked2      <= locked2_n;
            result       <= result_n;
            result_valid <= result_valid_n;
            score1       <= score1_n;
            score2       <= score2_n;
            match_over   <= match_over_n;
            winner       <= winner_n;
        end
    end

`ifdef RPS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            fft     <= 1'b0;
            forfeit <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            fft     <= fft_n;
            forfeit <= forfeit_n;
        end
    end
`else
    assign forfeit = 1'b0;
`endif

endmodule
